pacman_move_ctrl: RTL and testbench

- Computes Pacman's next grid position once per game tick and writes it into the Pacman coordinate register.
- Reads Pacman's current x/y from the register, applies the requested or current direction, and checks the target cell against the maze map memory.
- Drives a single-cycle write (en=1, readwrite=0) only when the move is legal.
- Sits directly upstream of the Pacman coordinate register, between the input/direction decoder and that register.

---
 rtl/pacman_move_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_move_ctrl.sv
// pacman_move_ctrl
//   Computes Pacman's next grid position on each game tick and issues a
//   single-cycle write to the Pacman coordinate register when the move is legal.
//   The desired direction is tried first. If that cell is blocked, the current
//   travel direction is tried next. If both are blocked, a stall pulse is
//   raised instead of a write.
//
// Ports:
//   clock_50, reset_n      clock, asynchronous active-low reset
//   tick                   one-cycle move strobe
//   dir_in, dir_valid      requested direction (00 up, 01 right, 10 down, 11 left)
//   cur_x, cur_y           current position from the coordinate register
//   map_x, map_y           maze map read address (registered)
//   map_type               map cell type, valid the cycle after the address
//   x_out, y_out           new position to the coordinate register
//   en, readwrite          write strobe (en=1, readwrite=0 for one cycle)
//   dir_out                current travel direction
//   busy                   high while a move is being evaluated
//   blocked                one-cycle pulse when a tick produces no move
module pacman_move_ctrl #(
    parameter int unsigned GRID_W    = 21,
    parameter int unsigned GRID_H    = 21,
    parameter logic [2:0]  WALL_TYPE = 3'd1,
    parameter logic [2:0]  GATE_TYPE = 3'd4
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic [4:0] cur_x,
    input  logic [4:0] cur_y,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic [2:0] map_type,
    output logic [4:0] x_out,
    output logic [4:0] y_out,
    output logic       en,
    output logic       readwrite,
    output logic [1:0] dir_out,
    output logic       busy,
    output logic       blocked
);

    localparam logic [4:0] XMAX = 5'(GRID_W - 1);
    localparam logic [4:0] YMAX = 5'(GRID_H - 1);

    typedef enum logic [2:0] {IDLE, ADDR_D, CHK_D, ADDR_C, CHK_C, WRITE, STALL} state_t;

    state_t     state_q, state_d;
    logic [1:0] desired_q, desired_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [4:0] snap_x_q, snap_x_d;
    logic [4:0] snap_y_q, snap_y_d;
    logic [1:0] snap_dir_q, snap_dir_d;
    logic [4:0] map_x_q, map_x_d;
    logic [4:0] map_y_q, map_y_d;
    logic [4:0] x_out_q, x_out_d;
    logic [4:0] y_out_q, y_out_d;
    logic       en_q, en_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       blocked_q, blocked_d;
    logic       passable;

    // Neighbouring cell in direction d, wrapping at the maze edges.
    function automatic logic [9:0] step(input logic [4:0] x, input logic [4:0] y,
                                        input logic [1:0] d);
        logic [4:0] nx;
        logic [4:0] ny;
        nx = x;
        ny = y;
        case (d)
            2'b00:   ny = (y == 5'd0) ? YMAX : y - 5'd1;
            2'b01:   nx = (x == XMAX) ? 5'd0 : x + 5'd1;
            2'b10:   ny = (y == YMAX) ? 5'd0 : y + 5'd1;
            default: nx = (x == 5'd0) ? XMAX : x - 5'd1;
        endcase
        return {nx, ny};
    endfunction

    assign passable = (map_type != WALL_TYPE) && (map_type != GATE_TYPE);

    // Outputs are registered: each *_d holds the value the output takes in
    // the state being entered, so addresses and strobes line up with state.
    always_comb begin
        state_d    = state_q;
        desired_d  = dir_valid ? dir_in : desired_q;
        cur_dir_d  = cur_dir_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_dir_d = snap_dir_q;
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        en_d       = 1'b0;
        rw_d       = 1'b1;
        blocked_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    snap_x_d           = cur_x;
                    snap_y_d           = cur_y;
                    snap_dir_d         = desired_q;
                    {map_x_d, map_y_d} = step(cur_x, cur_y, desired_q);
                    state_d            = ADDR_D;
                end
            end
            ADDR_D: state_d = CHK_D;
            CHK_D: begin
                if (passable) begin
                    x_out_d   = map_x_q;
                    y_out_d   = map_y_q;
                    cur_dir_d = snap_dir_q;
                    en_d      = 1'b1;
                    rw_d      = 1'b0;
                    state_d   = WRITE;
                end else if (snap_dir_q == cur_dir_q) begin
                    blocked_d = 1'b1;
                    state_d   = STALL;
                end else begin
                    {map_x_d, map_y_d} = step(snap_x_q, snap_y_q, cur_dir_q);
                    state_d            = ADDR_C;
                end
            end
            ADDR_C: state_d = CHK_C;
            CHK_C: begin
                if (passable) begin
                    x_out_d = map_x_q;
                    y_out_d = map_y_q;
                    en_d    = 1'b1;
                    rw_d    = 1'b0;
                    state_d = WRITE;
                end else begin
                    blocked_d = 1'b1;
                    state_d   = STALL;
                end
            end
            WRITE:   state_d = IDLE;
            STALL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            desired_q  <= 2'b11;
            cur_dir_q  <= 2'b11;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_dir_q <= 2'b11;
            map_x_q    <= '0;
            map_y_q    <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            en_q       <= 1'b0;
            rw_q       <= 1'b1;
            busy_q     <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            desired_q  <= desired_d;
            cur_dir_q  <= cur_dir_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_dir_q <= snap_dir_d;
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            en_q       <= en_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            blocked_q  <= blocked_d;
        end
    end

    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign en        = en_q;
    assign readwrite = rw_q;
    assign dir_out   = cur_dir_q;
    assign busy      = busy_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed testbench for pacman_move_ctrl with a behavioural synchronous map.
module tb_pacman_move_ctrl;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic [1:0] dir_in;
    logic       dir_valid;
    logic [4:0] cur_x, cur_y;
    logic [4:0] map_x, map_y;
    logic [2:0] map_type;
    logic [4:0] x_out, y_out;
    logic       en, readwrite, busy, blocked;
    logic [1:0] dir_out;

    int unsigned n_total;
    int unsigned n_bad;

    logic [2:0] maze [0:31][0:31];
    logic       en_s  [1:8];
    logic       rw_s  [1:8];
    logic       blk_s [1:8];
    logic       bsy_s [1:8];
    logic [4:0] mx_s  [1:8];
    logic [4:0] my_s  [1:8];

    pacman_move_ctrl #(.GRID_W(21), .GRID_H(21), .WALL_TYPE(3'd1), .GATE_TYPE(3'd4)) dut (
        .clock_50(clk), .reset_n(reset_n), .tick(tick), .dir_in(dir_in),
        .dir_valid(dir_valid), .cur_x(cur_x), .cur_y(cur_y), .map_x(map_x),
        .map_y(map_y), .map_type(map_type), .x_out(x_out), .y_out(y_out),
        .en(en), .readwrite(readwrite), .dir_out(dir_out), .busy(busy),
        .blocked(blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) map_type <= maze[map_x][map_y];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_maze();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                maze[i][j] = 3'd0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk);
        dir_valid = 1'b1;
        dir_in    = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    // Tick at edge 0; samples cycles 1..8 on the following negedges.
    task automatic run_tick(input logic [4:0] x, input logic [4:0] y, input bit extra,
                            input bit dv, input logic [1:0] dv_dir);
        @(negedge clk);
        cur_x = x;
        cur_y = y;
        tick  = 1'b1;
        if (dv) begin
            dir_valid = 1'b1;
            dir_in    = dv_dir;
        end
        @(negedge clk);
        tick      = 1'b0;
        dir_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            en_s[c]  = en;
            rw_s[c]  = readwrite;
            blk_s[c] = blocked;
            bsy_s[c] = busy;
            mx_s[c]  = map_x;
            my_s[c]  = map_y;
            if (extra && c == 2) tick = 1'b1;
            else if (extra && c == 3) tick = 1'b0;
        end
    endtask

    function automatic int count_en();
        int n;
        n = 0;
        for (int c = 1; c <= 8; c++) if (en_s[c]) n++;
        return n;
    endfunction

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        tick      = 1'b0;
        dir_in    = 2'b00;
        dir_valid = 1'b0;
        cur_x     = '0;
        cur_y     = '0;
        clear_maze();
        repeat (3) @(negedge clk);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_rw", {31'd0, readwrite}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_blk", {31'd0, blocked}, 32'd0);
        check("rst_xy", {22'd0, x_out, y_out}, 32'd0);
        check("rst_map", {22'd0, map_x, map_y}, 32'd0);
        check("rst_dir", {30'd0, dir_out}, 32'd3);
        reset_n = 1'b1;

        // Default left from (2,2).
        run_tick(5'd2, 5'd2, 1'b0, 1'b0, 2'b00);
        check("t1_busy1", {31'd0, bsy_s[1]}, 32'd1);
        check("t1_en2", {31'd0, en_s[2]}, 32'd0);
        check("t1_en3", {31'd0, en_s[3]}, 32'd1);
        check("t1_rw3", {31'd0, rw_s[3]}, 32'd0);
        check("t1_en4", {31'd0, en_s[4]}, 32'd0);
        check("t1_xy", {22'd0, x_out, y_out}, {22'd0, 5'd1, 5'd2});
        check("t1_dir", {30'd0, dir_out}, 32'd3);
        check("t1_busy5", {31'd0, bsy_s[5]}, 32'd0);

        // Desired right.
        set_dir(2'b01);
        run_tick(5'd2, 5'd2, 1'b0, 1'b0, 2'b00);
        check("t2_map1", {22'd0, mx_s[1], my_s[1]}, {22'd0, 5'd3, 5'd2});
        check("t2_en3", {31'd0, en_s[3]}, 32'd1);
        check("t2_xy", {22'd0, x_out, y_out}, {22'd0, 5'd3, 5'd2});
        check("t2_dir", {30'd0, dir_out}, 32'd1);

        // Desired up blocked, fall back to right.
        maze[2][1] = 3'd1;
        set_dir(2'b00);
        run_tick(5'd2, 5'd2, 1'b0, 1'b0, 2'b00);
        check("t3_map1", {22'd0, mx_s[1], my_s[1]}, {22'd0, 5'd2, 5'd1});
        check("t3_map3", {22'd0, mx_s[3], my_s[3]}, {22'd0, 5'd3, 5'd2});
        check("t3_en3", {31'd0, en_s[3]}, 32'd0);
        check("t3_en5", {31'd0, en_s[5]}, 32'd1);
        check("t3_rw5", {31'd0, rw_s[5]}, 32'd0);
        check("t3_xy", {22'd0, x_out, y_out}, {22'd0, 5'd3, 5'd2});
        check("t3_dir", {30'd0, dir_out}, 32'd1);

        // Both candidates blocked (wall up, gate right).
        maze[7][6] = 3'd1;
        maze[8][7] = 3'd4;
        run_tick(5'd7, 5'd7, 1'b0, 1'b0, 2'b00);
        check("t4_en_cnt", count_en(), 32'd0);
        check("t4_blk3", {31'd0, blk_s[3]}, 32'd0);
        check("t4_blk5", {31'd0, blk_s[5]}, 32'd1);
        check("t4_blk6", {31'd0, blk_s[6]}, 32'd0);
        check("t4_xy", {22'd0, x_out, y_out}, {22'd0, 5'd3, 5'd2});
        check("t4_dir", {30'd0, dir_out}, 32'd1);

        // Desired equals current and blocked: early stall.
        set_dir(2'b01);
        run_tick(5'd7, 5'd7, 1'b0, 1'b0, 2'b00);
        check("t5_blk3", {31'd0, blk_s[3]}, 32'd1);
        check("t5_blk5", {31'd0, blk_s[5]}, 32'd0);
        check("t5_en_cnt", count_en(), 32'd0);
        clear_maze();

        // Wrap-around.
        set_dir(2'b11);
        run_tick(5'd0, 5'd10, 1'b0, 1'b0, 2'b00);
        check("wrap_l_xy", {22'd0, x_out, y_out}, {22'd0, 5'd20, 5'd10});
        check("wrap_l_en3", {31'd0, en_s[3]}, 32'd1);
        set_dir(2'b01);
        run_tick(5'd20, 5'd10, 1'b0, 1'b0, 2'b00);
        check("wrap_r_xy", {22'd0, x_out, y_out}, {22'd0, 5'd0, 5'd10});
        set_dir(2'b00);
        run_tick(5'd5, 5'd0, 1'b0, 1'b0, 2'b00);
        check("wrap_u_xy", {22'd0, x_out, y_out}, {22'd0, 5'd5, 5'd20});
        check("wrap_u_dir", {30'd0, dir_out}, 32'd0);

        // Extra tick while busy is ignored.
        run_tick(5'd4, 5'd4, 1'b1, 1'b0, 2'b00);
        check("busy_tick_cnt", count_en(), 32'd1);
        check("busy_tick_xy", {22'd0, x_out, y_out}, {22'd0, 5'd4, 5'd3});

        // dir_valid with tick: old desired (up) used, new (right) next time.
        run_tick(5'd4, 5'd4, 1'b0, 1'b1, 2'b01);
        check("same_cyc_xy", {22'd0, x_out, y_out}, {22'd0, 5'd4, 5'd3});
        check("same_cyc_dir", {30'd0, dir_out}, 32'd0);
        run_tick(5'd4, 5'd4, 1'b0, 1'b0, 2'b00);
        check("next_tick_xy", {22'd0, x_out, y_out}, {22'd0, 5'd5, 5'd4});
        check("next_tick_dir", {30'd0, dir_out}, 32'd1);

        // Reset during ADDR_C.
        maze[4][3] = 3'd1;
        set_dir(2'b00);
        @(negedge clk);
        cur_x = 5'd4;
        cur_y = 5'd4;
        tick  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rc_map3", {22'd0, map_x, map_y}, {22'd0, 5'd5, 5'd4});
        check("rc_busy3", {31'd0, busy}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rc_en", {31'd0, en}, 32'd0);
        check("rc_busy", {31'd0, busy}, 32'd0);
        check("rc_rw", {31'd0, readwrite}, 32'd1);
        check("rc_xy", {22'd0, x_out, y_out}, 32'd0);
        check("rc_map", {22'd0, map_x, map_y}, 32'd0);
        check("rc_dir", {30'd0, dir_out}, 32'd3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rc_en_hold", {31'd0, en}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rc_post_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
